am_lock_rx: RTL and testbench

Per-lane alignment marker lock for the 40GBASE-R receive path, one instance per PCS lane. It sits between block sync and `deskew_rx`. It searches the incoming 66-bit block stream for any of the `LANE_N` alignment markers and confirms lock once a second marker for the same lane arrives exactly `AM_GAP` blocks later. It then produces the `am_lite_v` / `am_lite_lock_v` pair that `deskew_rx` consumes, with the data delayed to stay aligned to those flags.

---
 rtl/am_pkg.sv | 32 +++
 rtl/am_match.sv | 35 +++
 rtl/am_lock_rx.sv | 140 ++++++++++++++
 tb/tb_am_lock_rx.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Alignment marker constants and FSM state type shared by am_lock_rx, deskew_rx and their benches.
// Marker words hold M0 in [7:0] up to M6 in [55:48]; BIP3/BIP7 positions are zero and masked out.
package am_pkg;

   localparam logic [1:0] SYNC_CTRL    = 2'b10;
   localparam int         AM_INVLD_MAX = 4;

   localparam logic [63:0] AM_MASK  = 64'h00ff_ffff_00ff_ffff;
   localparam logic [63:0] AM_LANE0 = 64'h00b8_896f_0047_7690;
   localparam logic [63:0] AM_LANE1 = 64'h0019_3b0f_00e6_c4f0;
   localparam logic [63:0] AM_LANE2 = 64'h0064_9a3a_009b_65c5;
   localparam logic [63:0] AM_LANE3 = 64'h00c2_865d_003d_79a2;

   typedef enum logic [1:0] {
      AM_FIND    = 2'd0,
      AM_CONFIRM = 2'd1,
      AM_LOCK    = 2'd2
   } am_state_e;

   function automatic logic [63:0] am_marker(input int lane);
      logic [63:0] m;
      case (lane)
         0:       m = AM_LANE0;
         1:       m = AM_LANE1;
         2:       m = AM_LANE2;
         3:       m = AM_LANE3;
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/am_match.sv
// Combinational compare of one block against every lane's alignment marker, BIP bytes ignored.
module am_match
   import am_pkg::*;
#(
   parameter int LANE_N  = 4,
   parameter int BLOCK_W = 66,
   localparam int LANE_W = $clog2(LANE_N)
) (
   input  logic [BLOCK_W-1:0] block,
   output logic               hit,
   output logic [LANE_W-1:0]  hit_lane
);

   logic [LANE_N-1:0] hit_oh;

   always_comb begin
      for (int k = 0; k < LANE_N; k++) begin
         hit_oh[k] = (block[BLOCK_W-1 -: 2] == SYNC_CTRL) &&
                     ((block[63:0] & AM_MASK) == am_marker(k));
      end
   end

   // Markers are mutually distinct, so at most one bit of hit_oh is ever set.
   always_comb begin
      hit_lane = '0;
      for (int k = 0; k < LANE_N; k++) begin
         if (hit_oh[k]) begin
            hit_lane = LANE_W'(k);
         end
      end
   end

   assign hit = |hit_oh;

endmodule

// File: rtl/am_lock_rx.sv
// Per-lane alignment marker lock: finds a marker, confirms it one AM_GAP later, then tracks it.
// Outputs are registered one cycle behind the input so am_v_o lines up with the marker on data_o.
module am_lock_rx
   import am_pkg::*;
#(
   parameter int LANE_N  = 4,
   parameter int BLOCK_W = 66,
   parameter int AM_GAP  = 16384,
   localparam int LANE_W = $clog2(LANE_N)
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic               valid_i,
   input  logic               block_lock_i,
   input  logic [BLOCK_W-1:0] data_i,
   output logic               valid_o,
   output logic [BLOCK_W-1:0] data_o,
   output logic               am_v_o,
   output logic               lock_v_o,
   output logic [LANE_W-1:0]  lane_o
);

   localparam int CNT_W   = $clog2(AM_GAP);
   localparam int INVLD_W = $clog2(AM_INVLD_MAX + 1);
   localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(AM_GAP - 1);
   localparam logic [INVLD_W-1:0] INVLD_LAST = INVLD_W'(AM_INVLD_MAX - 1);

   am_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [INVLD_W-1:0]   invld_q, invld_d;
   logic [LANE_W-1:0]    lane_q, lane_d;
   logic                 valid_q, valid_d;
   logic [BLOCK_W-1:0]   data_q, data_d;
   logic                 am_v_q, am_v_d;
   logic                 lock_v_q, lock_v_d;

   logic                 hit;
   logic [LANE_W-1:0]    hit_lane;
   logic                 slot;
   logic                 lane_hit;

   am_match #(
      .LANE_N  (LANE_N),
      .BLOCK_W (BLOCK_W)
   ) u_match (
      .block    (data_i),
      .hit      (hit),
      .hit_lane (hit_lane)
   );

   assign slot     = (cnt_q == GAP_LAST);
   assign lane_hit = hit && (hit_lane == lane_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      invld_d  = invld_q;
      lane_d   = lane_q;
      am_v_d   = 1'b0;
      valid_d  = valid_i;
      data_d   = valid_i ? data_i : data_q;
      // Registering the pre-update state makes lock_v_o trail the confirming am_v_o by a cycle.
      lock_v_d = block_lock_i && (state_q == AM_LOCK);

      if (!block_lock_i) begin
         state_d = AM_FIND;
         cnt_d   = '0;
         invld_d = '0;
      end else if (valid_i) begin
         cnt_d = slot ? '0 : cnt_q + CNT_W'(1);
         case (state_q)
            AM_FIND: begin
               if (hit) begin
                  lane_d  = hit_lane;
                  cnt_d   = '0;
                  state_d = AM_CONFIRM;
               end
            end
            AM_CONFIRM: begin
               if (slot) begin
                  if (lane_hit) begin
                     am_v_d  = 1'b1;
                     invld_d = '0;
                     state_d = AM_LOCK;
                  end else if (hit) begin
                     // Falling back to search would take this marker as a new candidate anyway.
                     lane_d = hit_lane;
                     cnt_d  = '0;
                  end else begin
                     state_d = AM_FIND;
                  end
               end
            end
            AM_LOCK: begin
               if (slot) begin
                  if (lane_hit) begin
                     am_v_d  = 1'b1;
                     invld_d = '0;
                  end else if (invld_q == INVLD_LAST) begin
                     invld_d = '0;
                     state_d = AM_FIND;
                  end else begin
                     invld_d = invld_q + INVLD_W'(1);
                  end
               end
            end
            default: state_d = AM_FIND;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= AM_FIND;
         cnt_q    <= '0;
         invld_q  <= '0;
         lane_q   <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         am_v_q   <= 1'b0;
         lock_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         invld_q  <= invld_d;
         lane_q   <= lane_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         am_v_q   <= am_v_d;
         lock_v_q <= lock_v_d;
      end
   end

   assign valid_o  = valid_q;
   assign data_o   = data_q;
   assign am_v_o   = am_v_q;
   assign lock_v_o = lock_v_q;
   assign lane_o   = lane_q;

endmodule

// File: tb/tb_am_lock_rx.sv
// Bench for am_lock_rx with AM_GAP = 8: vector table, directed corner sequences and a random
// stream, all checked against a block-index based reference model.
module tb_am_lock_rx;

   localparam int GAP = 8;

   logic        clk = 1'b0;
   logic        nreset;
   logic        valid_i;
   logic        block_lock_i;
   logic [65:0] data_i;
   logic        valid_o;
   logic [65:0] data_o;
   logic        am_v_o;
   logic        lock_v_o;
   logic [1:0]  lane_o;

   int checks = 0;
   int errors = 0;

   logic [7:0] am_bytes [4][6] = '{
      '{8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8},
      '{8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19},
      '{8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64},
      '{8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2}
   };

   // Reference model: mode 0 searching, 1 candidate seen, 2 locked.
   int          m_mode;
   int          m_lane;
   longint      m_idx;
   longint      m_anchor;
   int          m_miss;
   bit          exp_valid;
   logic [65:0] exp_data;
   bit          exp_am;
   bit          exp_lock;
   int          exp_lane;

   typedef struct {
      bit v;
      bit bl;
      int mk;
      bit exp_am;
      bit exp_lock;
   } vec_t;

   vec_t vec_tbl [12];

   am_lock_rx #(
      .LANE_N  (4),
      .BLOCK_W (66),
      .AM_GAP  (GAP)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .valid_i      (valid_i),
      .block_lock_i (block_lock_i),
      .data_i       (data_i),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .am_v_o       (am_v_o),
      .lock_v_o     (lock_v_o),
      .lane_o       (lane_o)
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] make_marker(input int lane);
      logic [65:0] d;
      d[65:64] = 2'b10;
      d[7:0]   = am_bytes[lane][0];
      d[15:8]  = am_bytes[lane][1];
      d[23:16] = am_bytes[lane][2];
      d[31:24] = 8'($urandom);
      d[39:32] = am_bytes[lane][3];
      d[47:40] = am_bytes[lane][4];
      d[55:48] = am_bytes[lane][5];
      d[63:56] = 8'($urandom);
      return d;
   endfunction

   function automatic logic [65:0] make_corrupt(input int lane);
      logic [65:0] d;
      d = make_marker(lane);
      d[4] = ~d[4];
      return d;
   endfunction

   function automatic logic [65:0] make_data();
      return {2'b01, 32'($urandom), 32'($urandom)};
   endfunction

   function automatic int marker_lane(input logic [65:0] d);
      int r;
      r = -1;
      for (int k = 0; k < 4; k++) begin
         if (d[65:64] == 2'b10 && d[7:0] == am_bytes[k][0] && d[15:8] == am_bytes[k][1] &&
             d[23:16] == am_bytes[k][2] && d[39:32] == am_bytes[k][3] &&
             d[47:40] == am_bytes[k][4] && d[55:48] == am_bytes[k][5]) begin
            r = k;
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_mode    = 0;
      m_lane    = 0;
      m_idx     = 0;
      m_anchor  = 0;
      m_miss    = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_am    = 1'b0;
      exp_lock  = 1'b0;
      exp_lane  = 0;
   endtask

   // Slots are every GAP-th valid block counted from the marker that opened the candidate.
   task automatic model_step(input bit v, input bit bl, input logic [65:0] d);
      int  ml;
      bit  was_locked;
      bit  at_slot;
      ml         = marker_lane(d);
      was_locked = (m_mode == 2);
      exp_am     = 1'b0;
      if (!bl) begin
         m_mode = 0;
         m_miss = 0;
      end else if (v) begin
         m_idx++;
         at_slot = (m_mode != 0) && (((m_idx - m_anchor) % GAP) == 0);
         if (m_mode == 0) begin
            if (ml >= 0) begin
               m_mode   = 1;
               m_lane   = ml;
               m_anchor = m_idx;
            end
         end else if (m_mode == 1) begin
            if (at_slot) begin
               if (ml == m_lane) begin
                  exp_am = 1'b1;
                  m_mode = 2;
                  m_miss = 0;
               end else if (ml >= 0) begin
                  m_lane   = ml;
                  m_anchor = m_idx;
               end else begin
                  m_mode = 0;
               end
            end
         end else if (at_slot) begin
            if (ml == m_lane) begin
               exp_am = 1'b1;
               m_miss = 0;
            end else begin
               m_miss++;
               if (m_miss == 4) begin
                  m_mode = 0;
                  m_miss = 0;
               end
            end
         end
      end
      exp_lock  = bl && was_locked;
      exp_valid = v;
      if (v) exp_data = d;
      exp_lane = m_lane;
   endtask

   task automatic check_val(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      check_val("valid_o", 66'(valid_o), 66'(exp_valid));
      check_val("data_o", data_o, exp_data);
      check_val("am_v_o", 66'(am_v_o), 66'(exp_am));
      check_val("lock_v_o", 66'(lock_v_o), 66'(exp_lock));
      if (exp_am || exp_lock) check_val("lane_o", 66'(lane_o), 66'(exp_lane));
   endtask

   // Called at a falling edge; drives, lets the rising edge register, compares at the next fall.
   task automatic applyStimulus(input bit v, input bit bl, input logic [65:0] d);
      valid_i      = v;
      block_lock_i = bl;
      data_i       = d;
      @(posedge clk);
      model_step(v, bl, d);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic send_data(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, make_data());
   endtask

   task automatic do_reset();
      nreset       = 1'b0;
      valid_i      = 1'b0;
      block_lock_i = 1'b1;
      data_i       = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_val("rst_valid_o", 66'(valid_o), 66'(0));
      check_val("rst_data_o", data_o, 66'(0));
      check_val("rst_am_v_o", 66'(am_v_o), 66'(0));
      check_val("rst_lock_v_o", 66'(lock_v_o), 66'(0));
      check_val("rst_lane_o", 66'(lane_o), 66'(0));
      nreset = 1'b1;
   endtask

   task automatic lock_on(input int lane);
      applyStimulus(1'b1, 1'b1, make_marker(lane));
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(lane));
   endtask

   initial begin
      logic [65:0] held;
      int          v_cnt;
      int          rnd_lane;
      int          r;
      bit          v;
      bit          bl;
      logic [65:0] d;

      do_reset();

      // Table: lane 2 marker at blocks 0 and 8 with random data in between.
      for (int i = 0; i < 12; i++) vec_tbl[i] = '{v: 1'b1, bl: 1'b1, mk: -1, exp_am: 1'b0, exp_lock: 1'b0};
      vec_tbl[0].mk     = 2;
      vec_tbl[8].mk     = 2;
      vec_tbl[8].exp_am = 1'b1;
      for (int i = 9; i < 12; i++) vec_tbl[i].exp_lock = 1'b1;
      for (int i = 0; i < 12; i++) begin
         d = (vec_tbl[i].mk >= 0) ? make_marker(vec_tbl[i].mk) : make_data();
         applyStimulus(vec_tbl[i].v, vec_tbl[i].bl, d);
         check_val("tbl_am_v", 66'(am_v_o), 66'(vec_tbl[i].exp_am));
         check_val("tbl_lock_v", 66'(lock_v_o), 66'(vec_tbl[i].exp_lock));
         if (i >= 8) check_val("tbl_lane", 66'(lane_o), 66'(2));
      end

      // Second marker from another lane re-arms on that lane.
      do_reset();
      applyStimulus(1'b1, 1'b1, make_marker(1));
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(3));
      check_val("mm_no_am", 66'(am_v_o), 66'(0));
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(3));
      check_val("mm_am", 66'(am_v_o), 66'(1));
      send_data(1);
      check_val("mm_lock", 66'(lock_v_o), 66'(1));
      check_val("mm_lane", 66'(lane_o), 66'(3));

      // Loss of lock: three bad slots then a good one, then four bad slots.
      do_reset();
      lock_on(0);
      for (int k = 0; k < 3; k++) begin
         send_data(GAP - 1);
         applyStimulus(1'b1, 1'b1, make_corrupt(0));
      end
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(0));
      check_val("loss_recover_am", 66'(am_v_o), 66'(1));
      check_val("loss_recover_lock", 66'(lock_v_o), 66'(1));
      for (int k = 0; k < 4; k++) begin
         send_data(GAP - 1);
         applyStimulus(1'b1, 1'b1, (k == 2) ? make_marker(1) : make_corrupt(0));
      end
      check_val("loss_lock_at_4th", 66'(lock_v_o), 66'(1));
      send_data(1);
      check_val("loss_lock_dropped", 66'(lock_v_o), 66'(0));

      // Valid gap mid-period.
      do_reset();
      lock_on(1);
      send_data(3);
      held = data_o;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b1, make_marker(1));
         check_val("gap_data_held", data_o, held);
         check_val("gap_no_am", 66'(am_v_o), 66'(0));
      end
      send_data(GAP - 4);
      applyStimulus(1'b1, 1'b1, make_marker(1));
      check_val("gap_am", 66'(am_v_o), 66'(1));

      // block_lock_i drop coincident with an expected marker.
      do_reset();
      lock_on(2);
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b0, make_marker(2));
      check_val("bl_no_am", 66'(am_v_o), 66'(0));
      check_val("bl_lock_off", 66'(lock_v_o), 66'(0));
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(2));
      check_val("bl_first_marker", 66'(am_v_o), 66'(0));
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(2));
      check_val("bl_relock", 66'(am_v_o), 66'(1));

      // Asynchronous reset while a candidate is pending.
      do_reset();
      applyStimulus(1'b1, 1'b1, make_marker(0));
      send_data(3);
      #2 nreset = 1'b0;
      #1;
      check_val("arst_valid_o", 66'(valid_o), 66'(0));
      check_val("arst_data_o", data_o, 66'(0));
      check_val("arst_am_v_o", 66'(am_v_o), 66'(0));
      check_val("arst_lock_v_o", 66'(lock_v_o), 66'(0));
      check_val("arst_lane_o", 66'(lane_o), 66'(0));
      model_reset();
      @(negedge clk);
      nreset = 1'b1;
      send_data(3);
      applyStimulus(1'b1, 1'b1, make_marker(0));
      check_val("arst_find", 66'(am_v_o), 66'(0));
      send_data(GAP - 1);
      applyStimulus(1'b1, 1'b1, make_marker(0));
      check_val("arst_relock", 66'(am_v_o), 66'(1));

      // Random stream: mostly periodic markers with corruption, gaps and rare block lock drops.
      do_reset();
      v_cnt    = 0;
      rnd_lane = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 600 == 0) rnd_lane = int'($urandom_range(0, 3));
         v  = ($urandom_range(0, 9) != 0);
         bl = ($urandom_range(0, 399) != 0);
         d  = make_data();
         if (v) begin
            if (v_cnt % GAP == 0) begin
               r = int'($urandom_range(0, 99));
               if (r < 82)      d = make_marker(rnd_lane);
               else if (r < 92) d = make_corrupt(rnd_lane);
               else             d = make_marker((rnd_lane + 1 + int'($urandom_range(0, 2))) % 4);
            end else if ($urandom_range(0, 49) == 0) begin
               d = make_marker(int'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 199) != 0) v_cnt++;
         end else if ($urandom_range(0, 1) == 0) begin
            d = make_marker(rnd_lane);
         end
         applyStimulus(v, bl, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
